// File: rtl/sdram_port_arbiter.sv
// SDRAM port arbiter: fixed-priority ROM read ports with aging,
// tagged in-flight read tracking, and IOCTL download pass-through.
module sdram_port_arbiter #(
   parameter int NUM_PORTS    = 4,
   parameter int ADDR_WIDTH   = 23,
   parameter int STARVE_LIMIT = 15,
   parameter int MAX_PENDING  = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_PORTS-1:0]            port_req,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
   output logic [NUM_PORTS-1:0]            port_ack,
   output logic [NUM_PORTS-1:0]            port_valid,
   input  logic                            dl_active,
   input  logic                            dl_req,
   input  logic [ADDR_WIDTH-1:0]           dl_addr,
   input  logic [31:0]                     dl_data,
   output logic                            dl_ack,
   output logic                            sdram_req,
   output logic                            sdram_we,
   output logic [ADDR_WIDTH-1:0]           sdram_addr,
   output logic [31:0]                     sdram_data,
   input  logic                            sdram_ack,
   input  logic                            sdram_valid,
   output logic                            protocol_err
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam int FW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int NW = $clog2(MAX_PENDING + 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REQ      = 2'd1;
   localparam logic [1:0] DL_DRAIN = 2'd2;
   localparam logic [1:0] DL       = 2'd3;

   localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

   logic [1:0]            state;
   logic [PW-1:0]         gnt_idx;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [CW-1:0]         wait_cnt [NUM_PORTS];
   logic [PW-1:0]         fifo [MAX_PENDING];
   logic [FW-1:0]         wr_ptr;
   logic [FW-1:0]         rd_ptr;
   logic [NW-1:0]         count;

   logic                  any_req;
   logic                  st_any;
   logic [PW-1:0]         lo_idx;
   logic [PW-1:0]         st_idx;
   logic [PW-1:0]         pick;
   logic                  can_grant;
   logic                  push;
   logic                  pop;
   logic                  is_dl;

   // Scan downward so the last hit is the lowest index.
   always_comb begin
      any_req = 1'b0;
      st_any  = 1'b0;
      lo_idx  = '0;
      st_idx  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_req[i]) begin
            any_req = 1'b1;
            lo_idx  = PW'(i);
            if (wait_cnt[i] == CW'(STARVE_LIMIT)) begin
               st_any = 1'b1;
               st_idx = PW'(i);
            end
         end
      end
      pick = st_any ? st_idx : lo_idx;
   end

   assign can_grant = (state == IDLE) && !dl_active && any_req &&
                      (count != NW'(MAX_PENDING));
   assign is_dl = (state == DL);
   assign push  = (state == REQ) && sdram_ack;
   assign pop   = sdram_valid && !is_dl && (count != '0);

   assign port_ack   = push ? (ONE << gnt_idx) : '0;
   assign port_valid = pop ? (ONE << fifo[rd_ptr]) : '0;

   assign sdram_req  = is_dl ? dl_req : (state == REQ);
   assign sdram_we   = is_dl;
   assign sdram_addr = is_dl ? dl_addr : addr_r;
   assign sdram_data = is_dl ? dl_data : 32'd0;
   assign dl_ack     = is_dl & sdram_ack;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         gnt_idx      <= '0;
         addr_r       <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dl_active) begin
                  state <= DL_DRAIN;
               end else if (can_grant) begin
                  state   <= REQ;
                  gnt_idx <= pick;
                  addr_r  <= port_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
               end
            end
            REQ: if (sdram_ack) state <= IDLE;
            DL_DRAIN: begin
               if (!dl_active) state <= IDLE;
               else if (count == '0) state <= DL;
            end
            DL: if (!dl_active) state <= IDLE;
         endcase

         if (push) begin
            fifo[wr_ptr] <= gnt_idx;
            wr_ptr <= (wr_ptr == FW'(MAX_PENDING - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == FW'(MAX_PENDING - 1)) ? '0 : rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         if (sdram_valid && !is_dl && count == '0) protocol_err <= 1'b1;

         // The port currently being served is not considered waiting.
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!port_req[i] ||
                (can_grant && pick == PW'(i)) ||
                (state == REQ && gnt_idx == PW'(i)))
               wait_cnt[i] <= '0;
            else if (wait_cnt[i] != CW'(STARVE_LIMIT))
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter: grant order, aging,
// tag routing, download pass-through, protocol error and reset.
module tb_sdram_port_arbiter;

   localparam int NP = 4;
   localparam int AW = 23;

   localparam logic [AW-1:0] A0 = 23'h000A00;
   localparam logic [AW-1:0] A1 = 23'h011111;
   localparam logic [AW-1:0] A2 = 23'h022222;
   localparam logic [AW-1:0] A3 = 23'h033333;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NP-1:0]     port_req;
   logic [NP*AW-1:0]  port_addr;
   logic [NP-1:0]     port_ack;
   logic [NP-1:0]     port_valid;
   logic              dl_active;
   logic              dl_req;
   logic [AW-1:0]     dl_addr;
   logic [31:0]       dl_data;
   logic              dl_ack;
   logic              sdram_req;
   logic              sdram_we;
   logic [AW-1:0]     sdram_addr;
   logic [31:0]       sdram_data;
   logic              sdram_ack;
   logic              sdram_valid;
   logic              protocol_err;

   int n_checks = 0;
   int n_fail   = 0;

   sdram_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW),
      .STARVE_LIMIT(15), .MAX_PENDING(2)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .port_req(port_req), .port_addr(port_addr),
      .port_ack(port_ack), .port_valid(port_valid),
      .dl_active(dl_active), .dl_req(dl_req),
      .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
      .sdram_req(sdram_req), .sdram_we(sdram_we),
      .sdram_addr(sdram_addr), .sdram_data(sdram_data),
      .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int  acks[$];
   logic pend;
   int  n0;

   initial begin
      reset_n     = 1'b0;
      port_req    = '0;
      port_addr   = {A3, A2, A1, A0};
      dl_active   = 1'b0;
      dl_req      = 1'b0;
      dl_addr     = '0;
      dl_data     = '0;
      sdram_ack   = 1'b0;
      sdram_valid = 1'b0;
      tick();
      tick();
      check("rst_sdram_req", sdram_req, 0);
      check("rst_port_ack", port_ack, 0);
      check("rst_port_valid", port_valid, 0);
      check("rst_we", sdram_we, 0);
      check("rst_dl_ack", dl_ack, 0);
      check("rst_err", protocol_err, 0);
      reset_n = 1'b1;
      tick();

      // Ports 1 and 3 together, ack after two REQ cycles
      port_req = 4'b1010;
      #1 check("t1_idle", sdram_req, 0);
      tick();
      check("t1_req", sdram_req, 1);
      check("t1_addr", sdram_addr, A1);
      check("t1_we", sdram_we, 0);
      check("t1_noack", port_ack, 0);
      tick();
      check("t1_hold", sdram_req, 1);
      sdram_ack = 1'b1;
      #1 check("t1_ack1", port_ack, 4'b0010);
      tick();
      sdram_ack = 1'b0;
      port_req  = 4'b1000;
      #1 check("t1_bubble", sdram_req, 0);
      tick();
      check("t1_req3", sdram_req, 1);
      check("t1_addr3", sdram_addr, A3);
      sdram_ack = 1'b1;
      #1 check("t1_ack3", port_ack, 4'b1000);
      tick();
      sdram_ack   = 1'b0;
      port_req    = '0;
      sdram_valid = 1'b1;
      #1 check("t1_val1", port_valid, 4'b0010);
      tick();
      check("t1_val3", port_valid, 4'b1000);
      tick();
      sdram_valid = 1'b0;

      // Port 0 continuous, port 2 waits until aged
      pend = 1'b0;
      port_req = 4'b0101;
      for (int t = 0; t < 24; t++) begin
         if (t == 20) port_req[0] = 1'b0;
         sdram_ack   = sdram_req;
         sdram_valid = pend;
         #1;
         pend = sdram_ack;
         for (int p = 0; p < NP; p++) begin
            if (port_ack[p]) begin
               acks.push_back(p);
               if (p == 2) port_req[2] = 1'b0;
            end
         end
         tick();
      end
      sdram_ack   = 1'b0;
      sdram_valid = 1'b0;
      n0 = 0;
      for (int k = 0; k < 8 && k < acks.size(); k++)
         if (acks[k] == 0) n0++;
      check("t2_nacks", acks.size(), 10);
      check("t2_p0_first8", n0, 8);
      if (acks.size() == 10) begin
         check("t2_p2_aged", acks[8], 2);
         check("t2_p0_resume", acks[9], 0);
      end
      check("t2_err", protocol_err, 0);

      // Two reads outstanding block a third port
      port_req = 4'b0100;
      tick();
      sdram_ack = 1'b1;
      #1 check("t3_ack2", port_ack, 4'b0100);
      tick();
      sdram_ack = 1'b0;
      port_req  = 4'b0001;
      tick();
      sdram_ack = 1'b1;
      #1 check("t3_ack0", port_ack, 4'b0001);
      tick();
      sdram_ack = 1'b0;
      port_req  = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_blocked", sdram_req, 0);
      end
      sdram_valid = 1'b1;
      #1 check("t3_val2", port_valid, 4'b0100);
      check("t3_still_blocked", sdram_req, 0);
      tick();
      sdram_valid = 1'b0;
      #1 check("t3_grant_cycle", sdram_req, 0);
      tick();
      check("t3_req1", sdram_req, 1);
      check("t3_addr1", sdram_addr, A1);

      // Ack and valid together with one pending
      sdram_ack   = 1'b1;
      sdram_valid = 1'b1;
      #1 check("t4_ack", port_ack, 4'b0010);
      check("t4_val", port_valid, 4'b0001);
      tick();
      sdram_ack   = 1'b0;
      sdram_valid = 1'b0;
      port_req    = '0;

      // Download request arrives during REQ
      port_req = 4'b1000;
      tick();
      dl_active = 1'b1;
      #1 check("t5_req_kept", sdram_req, 1);
      check("t5_we0", sdram_we, 0);
      check("t5_dlack0", dl_ack, 0);
      tick();
      sdram_ack = 1'b1;
      #1 check("t5_ack3", port_ack, 4'b1000);
      tick();
      sdram_ack = 1'b0;
      port_req  = '0;
      #1 check("t5_idle", sdram_req, 0);
      tick();
      dl_req  = 1'b1;
      dl_addr = 23'h000100;
      dl_data = 32'hDEADBEEF;
      #1 check("t5_drain_we", sdram_we, 0);
      check("t5_drain_req", sdram_req, 0);
      sdram_valid = 1'b1;
      #1 check("t5_val1", port_valid, 4'b0010);
      tick();
      check("t5_val3", port_valid, 4'b1000);
      tick();
      sdram_valid = 1'b0;
      #1 check("t5_drain_last", sdram_we, 0);
      tick();
      check("t5_dl_req", sdram_req, 1);
      check("t5_dl_we", sdram_we, 1);
      check("t5_dl_addr", sdram_addr, 23'h000100);
      check("t5_dl_data", sdram_data, 32'hDEADBEEF);
      check("t5_dl_ack0", dl_ack, 0);
      sdram_ack   = 1'b1;
      sdram_valid = 1'b1;
      #1 check("t5_dl_ack1", dl_ack, 1);
      check("t5_dl_noval", port_valid, 0);
      check("t5_dl_noack", port_ack, 0);
      tick();
      sdram_ack   = 1'b0;
      sdram_valid = 1'b0;
      check("t5_dl_err", protocol_err, 0);
      dl_req    = 1'b0;
      dl_active = 1'b0;
      tick();
      check("t5_back_we", sdram_we, 0);
      check("t5_back_req", sdram_req, 0);

      // Stray valid, then reset during REQ
      sdram_valid = 1'b1;
      #1 check("t6_stray_val", port_valid, 0);
      tick();
      sdram_valid = 1'b0;
      check("t6_err", protocol_err, 1);
      port_req = 4'b0001;
      tick();
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      tick();
      check("t6_req_before_rst", sdram_req, 1);
      reset_n = 1'b0;
      tick();
      check("t6_rst_req", sdram_req, 0);
      check("t6_rst_err", protocol_err, 0);
      check("t6_rst_ack", port_ack, 0);
      reset_n  = 1'b1;
      port_req = '0;
      tick();
      sdram_valid = 1'b1;
      #1 check("t6_fifo_empty", port_valid, 0);
      tick();
      sdram_valid = 1'b0;
      check("t6_err_after", protocol_err, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
